prog_time_base_gen: RTL and testbench

// Multi-channel programmable time base generator: N_CH independent modulo counters,

---
 rtl/prog_time_base_gen.sv | 133 +++++++++++++
 tb/tb_prog_time_base_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_time_base_gen.sv
// Multi-channel programmable time base: per-channel modulo counters emitting one-cycle
// tick pulses, with shadowed divisor/mode registers applied at wrap or on global sync.
module prog_time_base_gen #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [N_CH-1:0]                           en,
  input  logic                                      sync,
  input  logic                                      cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]                          cfg_div,
  input  logic                                      cfg_oneshot,
  output logic [N_CH-1:0]                           tick,
  output logic [N_CH-1:0]                           done,
  output logic                                      cfg_err
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [WIDTH-1:0] cnt_q     [N_CH];
  logic [WIDTH-1:0] cnt_d     [N_CH];
  logic [WIDTH-1:0] div_act_q [N_CH];
  logic [WIDTH-1:0] div_act_d [N_CH];
  logic [WIDTH-1:0] div_sh_q  [N_CH];
  logic [WIDTH-1:0] div_sh_d  [N_CH];
  logic [N_CH-1:0]  mode_act_q, mode_act_d;
  logic [N_CH-1:0]  mode_sh_q,  mode_sh_d;
  logic [N_CH-1:0]  pend_q,     pend_d;
  logic [N_CH-1:0]  tick_q,     tick_d;
  logic [N_CH-1:0]  done_q,     done_d;
  logic             cfg_err_q,  cfg_err_d;

  // Next-state: write decode, per-channel count/wrap, shadow hand-off.
  always_comb begin
    logic ch_ok;
    logic wr_ok;
    logic wr_c;
    logic wrap_c;

    ch_ok      = 1'b0;
    wr_ok      = 1'b0;
    wr_c       = 1'b0;
    wrap_c     = 1'b0;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_sh_d   = div_sh_q;
    mode_act_d = mode_act_q;
    mode_sh_d  = mode_sh_q;
    pend_d     = pend_q;
    done_d     = done_q;
    tick_d     = '0;

    // Explicit match avoids relying on an out-of-range compare when N_CH is a power of two.
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (cfg_ch == CH_W'(c)) ch_ok = 1'b1;
    end
    wr_ok     = cfg_we & (cfg_div != '0) & ch_ok;
    cfg_err_d = cfg_we & ~wr_ok;

    for (int unsigned c = 0; c < N_CH; c++) begin
      wr_c   = wr_ok & (cfg_ch == CH_W'(c));
      wrap_c = en[c] & ~done_q[c] & (cnt_q[c] == div_act_q[c] - WIDTH'(1));

      if (sync) begin
        cnt_d[c]  = '0;
        done_d[c] = 1'b0;
        pend_d[c] = 1'b0;
        if (wr_c) begin
          div_act_d[c]  = cfg_div;
          mode_act_d[c] = cfg_oneshot;
          div_sh_d[c]   = cfg_div;
          mode_sh_d[c]  = cfg_oneshot;
        end else if (pend_q[c]) begin
          div_act_d[c]  = div_sh_q[c];
          mode_act_d[c] = mode_sh_q[c];
        end
      end else begin
        if (wrap_c) begin
          cnt_d[c]  = '0;
          tick_d[c] = 1'b1;
          if (mode_act_q[c]) done_d[c] = 1'b1;
          if (pend_q[c]) begin
            div_act_d[c]  = div_sh_q[c];
            mode_act_d[c] = mode_sh_q[c];
            pend_d[c]     = 1'b0;
          end
        end else if (en[c] & ~done_q[c]) begin
          cnt_d[c] = cnt_q[c] + WIDTH'(1);
        end
        // A write landing on a wrap cycle stays pending for the following period.
        if (wr_c) begin
          div_sh_d[c]  = cfg_div;
          mode_sh_d[c] = cfg_oneshot;
          pend_d[c]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        cnt_q[c]     <= '0;
        div_act_q[c] <= WIDTH'(DEFAULT_DIV);
        div_sh_q[c]  <= WIDTH'(DEFAULT_DIV);
      end
      mode_act_q <= '0;
      mode_sh_q  <= '0;
      pend_q     <= '0;
      tick_q     <= '0;
      done_q     <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_sh_q   <= div_sh_d;
      mode_act_q <= mode_act_d;
      mode_sh_q  <= mode_sh_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_prog_time_base_gen.sv
// Bench for prog_time_base_gen: a 4-channel and a 3-channel instance share stimulus and are
// checked against a per-channel behavioural model, hand-computed tables and corner sequences.
module tb_prog_time_base_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  en;
  logic        sync;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_oneshot;
  logic [3:0]  tick_a, done_a;
  logic        err_a;
  logic [2:0]  tick_b, done_b;
  logic        err_b;

  always #5 clk = ~clk;

  prog_time_base_gen #(.N_CH(4), .WIDTH(16), .DEFAULT_DIV(5)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .tick(tick_a), .done(done_a), .cfg_err(err_a)
  );

  prog_time_base_gen #(.N_CH(3), .WIDTH(16), .DEFAULT_DIV(5)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .en(en[2:0]), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .tick(tick_b), .done(done_b), .cfg_err(err_b)
  );

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  // Model state per instance (0: 4 channels, 1: 3 channels) and channel.
  int m_cnt [2][4];
  int m_dact[2][4];
  int m_dsh [2][4];
  int m_mact[2][4];
  int m_msh [2][4];
  int m_pend[2][4];
  int m_tick[2][4];
  int m_done[2][4];
  int m_err [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      for (int c = 0; c < 4; c++) begin
        m_cnt[i][c] = 0;  m_dact[i][c] = 5; m_dsh[i][c] = 5;
        m_mact[i][c] = 0; m_msh[i][c] = 0;  m_pend[i][c] = 0;
        m_tick[i][c] = 0; m_done[i][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    int  lim;
    bit  valid;
    for (int i = 0; i < 2; i++) begin
      lim      = (i == 0) ? 4 : 3;
      valid    = cfg_we && (cfg_div != 0) && (int'(cfg_ch) < lim);
      m_err[i] = (cfg_we && !valid) ? 1 : 0;
      for (int c = 0; c < lim; c++) begin
        bit w;
        w = valid && (int'(cfg_ch) == c);
        m_tick[i][c] = 0;
        if (sync) begin
          m_cnt[i][c] = 0;
          m_done[i][c] = 0;
          if (w) begin
            m_dact[i][c] = int'(cfg_div); m_mact[i][c] = int'(cfg_oneshot);
            m_dsh[i][c]  = int'(cfg_div); m_msh[i][c]  = int'(cfg_oneshot);
          end else if (m_pend[i][c] != 0) begin
            m_dact[i][c] = m_dsh[i][c]; m_mact[i][c] = m_msh[i][c];
          end
          m_pend[i][c] = 0;
        end else begin
          if (en[c] && m_done[i][c] == 0) begin
            if (m_cnt[i][c] == m_dact[i][c] - 1) begin
              m_cnt[i][c]  = 0;
              m_tick[i][c] = 1;
              if (m_mact[i][c] != 0) m_done[i][c] = 1;
              if (m_pend[i][c] != 0) begin
                m_dact[i][c] = m_dsh[i][c]; m_mact[i][c] = m_msh[i][c]; m_pend[i][c] = 0;
              end
            end else begin
              m_cnt[i][c] = m_cnt[i][c] + 1;
            end
          end
          if (w) begin
            m_dsh[i][c] = int'(cfg_div); m_msh[i][c] = int'(cfg_oneshot); m_pend[i][c] = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [3:0] mvec(input int i, input bit sel_done);
    logic [3:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[c] = sel_done ? (m_done[i][c] != 0) : (m_tick[i][c] != 0);
    return v;
  endfunction

  task automatic compare_all();
    chk("tick_a", 32'(tick_a), 32'(mvec(0, 1'b0)));
    chk("done_a", 32'(done_a), 32'(mvec(0, 1'b1)));
    chk("err_a",  32'(err_a),  32'(m_err[0]));
    chk("tick_b", 32'(tick_b), 32'(mvec(1, 1'b0)));
    chk("done_b", 32'(done_b), 32'(mvec(1, 1'b1)));
    chk("err_b",  32'(err_b),  32'(m_err[1]));
  endtask

  task automatic cycle(input logic [3:0] e, input logic s, input logic w, input logic [1:0] ch,
                       input logic [15:0] d, input logic os);
    en = e; sync = s; cfg_we = w; cfg_ch = ch; cfg_div = d; cfg_oneshot = os;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic idle(input logic [3:0] e);
    cycle(e, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  en;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] div;
    logic [3:0]  exp_tick;
    logic        exp_err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Row k is applied before posedge k+1; expectations are the outputs after that edge.
    for (int k = 0; k < 12; k++) begin
      tbl[k].en       = 4'hF;
      tbl[k].we       = 1'b0;
      tbl[k].ch       = 2'd0;
      tbl[k].div      = 16'd0;
      tbl[k].exp_tick = (k == 4 || k == 9) ? 4'hF : 4'h0;
      tbl[k].exp_err  = 1'b0;
    end
    tbl[6].we = 1'b1;  tbl[6].ch = 2'd2; tbl[6].div = 16'd0; tbl[6].exp_err = 1'b1;
    tbl[7].we = 1'b1;  tbl[7].ch = 2'd3; tbl[7].div = 16'd4;
    tbl[10].we = 1'b1; tbl[10].ch = 2'd1; tbl[10].div = 16'd0; tbl[10].exp_err = 1'b1;

    reset_n = 1'b0; en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_oneshot = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tick_a", 32'(tick_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_err_a",  32'(err_a),  32'd0);
    chk("rst_tick_b", 32'(tick_b), 32'd0);
    reset_n = 1'b1;

    // Default period, rejected writes, write applied at wrap.
    for (int k = 0; k < 12; k++) begin
      cycle(tbl[k].en, 1'b0, tbl[k].we, tbl[k].ch, tbl[k].div, 1'b0);
      chk("tbl_tick", 32'(tick_a), 32'(tbl[k].exp_tick));
      chk("tbl_err",  32'(err_a),  32'(tbl[k].exp_err));
    end

    // Mid-period divisor change on ch1: old period completes at 15, then every 3.
    for (int k = 13; k <= 21; k++) begin
      if (k == 13) cycle(4'hF, 1'b0, 1'b1, 2'd1, 16'd3, 1'b0);
      else idle(4'hF);
      chk("t2_tick1", 32'(tick_a[1]), (k == 15 || k == 18 || k == 21) ? 32'd1 : 32'd0);
      chk("t2_tick0", 32'(tick_a[0]), (k == 15 || k == 20) ? 32'd1 : 32'd0);
    end

    // One-shot on ch0 armed by sync, then re-armed by a sync carrying a rejected write.
    cycle(4'hF, 1'b0, 1'b1, 2'd0, 16'd4, 1'b1);
    cycle(4'hF, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      idle(4'hF);
      chk("t4_tick0", 32'(tick_a[0]), (k == 4) ? 32'd1 : 32'd0);
      chk("t4_done0", 32'(done_a[0]), (k >= 4) ? 32'd1 : 32'd0);
    end
    cycle(4'hF, 1'b1, 1'b1, 2'd2, 16'd0, 1'b0);
    chk("t4_sync_err", 32'(err_a), 32'd1);
    chk("t4_sync_done", 32'(done_a[0]), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      idle(4'hF);
      chk("t4_refire", 32'(tick_a[0]), (k == 4) ? 32'd1 : 32'd0);
    end

    // div=1 on ch3: tick follows en[3] every cycle, including across a freeze.
    cycle(4'hF, 1'b0, 1'b1, 2'd3, 16'd1, 1'b0);
    cycle(4'hF, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      logic [3:0] e;
      e = (k >= 4 && k <= 6) ? 4'h7 : 4'hF;
      idle(e);
      chk("t5_tick3", 32'(tick_a[3]), 32'(e[3]));
    end

    // Asynchronous reset mid-period with a pending write that must be discarded.
    chk("t6_pre_done0", 32'(done_a[0]), 32'd1);
    cycle(4'hF, 1'b0, 1'b1, 2'd1, 16'd7, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_tick_a", 32'(tick_a), 32'd0);
    chk("t6_done_a", 32'(done_a), 32'd0);
    chk("t6_err_a",  32'(err_a),  32'd0);
    chk("t6_done_b", 32'(done_b), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      idle(4'hF);
      chk("t6_period", 32'(tick_a), (k == 5 || k == 10) ? 32'hF : 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] e;
      e = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      cycle(e, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 16'($urandom_range(0, 8)), ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
